fifo_wptr_full: RTL

Write-domain pointer and full-flag stage of the async FIFO.
- Counts accepted writes and drives the binary memory write address.
- Produces the registered Gray write pointer that the pointer synchroniser carries into the read domain.
- Compares its next Gray pointer against the read pointer (already synchronised into this domain) to flag full, almost-full, fill level and overflow.

---
 rtl/fifo_wptr_full.sv | 89 ++++++++
 1 files changed

// File: rtl/fifo_wptr_full.sv
// Async FIFO write side: binary/Gray write pointer, full, almost-full, level, overflow.
// FIFO_WOVF_STICKY_EN makes wovf sticky until ovf_clr; otherwise it is a one-cycle pulse.
module fifo_wptr_full #(
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic              ovf_clr,
    input  logic [ADDR_W:0]   rq2_rptr,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W-1:0] waddr,
    output logic              wen,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              wovf
);

    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] level_next;
    logic [ADDR_W:0] full_cmp;
    logic            ovf_evt;

    assign wen        = winc & ~wfull & ~rst;
    assign ovf_evt    = winc & wfull & ~rst;
    assign wbin_next  = wbin + {{ADDR_W{1'b0}}, wen};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign waddr      = wbin[ADDR_W-1:0];

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign full_cmp = {~rq2_rptr[ADDR_W:ADDR_W-1], rq2_rptr[ADDR_W-2:0]};

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(rq2_rptr >> i);
        end
    end

    assign level_next = wbin_next - rbin;

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= (wgray_next == full_cmp);
            walmost_full <= (level_next >= AF_LVL);
            wlevel       <= level_next;
        end
    end

`ifdef FIFO_WOVF_STICKY_EN
    // A new overflow beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            wovf <= 1'b0;
        end else if (ovf_evt) begin
            wovf <= 1'b1;
        end else if (ovf_clr) begin
            wovf <= 1'b0;
        end
    end
`else
    logic ovf_clr_unused;
    assign ovf_clr_unused = ovf_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wovf <= 1'b0;
        end else begin
            wovf <= ovf_evt;
        end
    end
`endif

endmodule
